// File: rtl/radar_track_unit.sv
// Radar ping/track controller: emits pulses, times echoes, and flags closing targets.
// Optional listen timeout is enabled by defining RTU_TIMEOUT_EN.
module radar_track_unit #(
    parameter int WIDTH           = 32,
    parameter int PULSE_CYCLES    = 50,
    parameter int SPEED_PER_CYCLE = 300,
    parameter int TIMEOUT_CYCLES  = 20000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             scan_for_target,
    input  logic             radar_echo,
    input  logic [WIDTH-1:0] jet_speed,
    input  logic [WIDTH-1:0] max_safe_distance,
    output logic             radar_pulse_trigger,
    output logic [WIDTH-1:0] distance_to_target,
    output logic             threat_detected,
    output logic             no_echo,
    output logic [1:0]       rtu_state
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EMIT   = 2'b01,
        LISTEN = 2'b10,
        ASSESS = 2'b11
    } state_t;

    state_t           state;
    logic [PW-1:0]    pulse_cnt;
    logic [WIDTH-1:0] timer;
    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] half;
    logic [WIDTH-1:0] echo_dist;
    logic             threat;

    assign rtu_state = state;

    // Round trip time to one-way distance, saturated to the datapath width.
    always_comb begin
        prod      = {{WIDTH{1'b0}}, timer} * (2*WIDTH)'(SPEED_PER_CYCLE);
        half      = prod >> 1;
        echo_dist = (|half[2*WIDTH-1:WIDTH]) ? '1 : half[WIDTH-1:0];
    end

    always_comb begin
        threat = (distance_to_target < max_safe_distance) &&
                 (prev > distance_to_target) &&
                 ((prev - distance_to_target) > jet_speed);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state               <= IDLE;
            radar_pulse_trigger <= 1'b0;
            distance_to_target  <= '0;
            threat_detected     <= 1'b0;
            pulse_cnt           <= '0;
            timer               <= '0;
            prev                <= '0;
            prev_valid          <= 1'b0;
`ifdef RTU_TIMEOUT_EN
            no_echo             <= 1'b0;
`endif
        end else begin
`ifdef RTU_TIMEOUT_EN
            no_echo <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    radar_pulse_trigger <= 1'b0;
                    if (scan_for_target) begin
                        state               <= EMIT;
                        radar_pulse_trigger <= 1'b1;
                        pulse_cnt           <= '0;
                    end
                end
                EMIT: begin
                    if (pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
                        state               <= LISTEN;
                        radar_pulse_trigger <= 1'b0;
                        timer               <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                LISTEN: begin
                    if (radar_echo) begin
                        distance_to_target <= echo_dist;
                        if (prev_valid) begin
                            state <= ASSESS;
                        end else begin
                            prev                <= echo_dist;
                            prev_valid          <= 1'b1;
                            state               <= EMIT;
                            radar_pulse_trigger <= 1'b1;
                            pulse_cnt           <= '0;
                        end
                    end
`ifdef RTU_TIMEOUT_EN
                    else if (timer == WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        state           <= IDLE;
                        no_echo         <= 1'b1;
                        threat_detected <= 1'b0;
                        prev_valid      <= 1'b0;
                    end
`endif
                    else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                ASSESS: begin
                    threat_detected <= threat;
                    if (threat) begin
                        prev                <= distance_to_target;
                        state               <= EMIT;
                        radar_pulse_trigger <= 1'b1;
                        pulse_cnt           <= '0;
                    end else begin
                        prev_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef RTU_TIMEOUT_EN
    assign no_echo = 1'b0;
`endif

endmodule
